// File: rtl/warp_xdiv.sv
// RV64 M-extension divide/remainder unit: restoring radix-2, one quotient bit per cycle.
// Zero-divisor and signed-overflow results take a shortcut straight to writeback.
//
// state  | meaning
// S_IDLE | ready for an op; special cases resolve here
// S_CALC | iterating, r_cnt counts remaining iterations down to 0
// S_DONE | result held for writeback until i_wb_ready
module warp_xdiv (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [63:0] i_op1,
   input  logic [63:0] i_op2,
   input  logic        i_unsigned,
   input  logic        i_word,
   input  logic        i_rem,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [4:0]  i_rd,
   output logic        o_wb_valid,
   input  logic        i_wb_ready,
   output logic [4:0]  o_wb_rd,
   output logic [63:0] o_wb_data,
   output logic [31:0] o_retire
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t      r_state, w_state_nxt;
   logic [5:0]  r_cnt;
   logic [63:0] r_quo, r_rem, r_div, r_result;
   logic        r_neg_q, r_neg_r, r_word, r_sel_rem;
   logic [4:0]  r_rd;
   logic [31:0] r_mask;

   logic [63:0] w_a64, w_b64, w_a_mag, w_b_mag;
   logic        w_a_neg, w_b_neg, w_div0, w_ovf, w_special, w_accept;
   logic [63:0] w_spec_raw, w_spec_res;
   logic [31:0] w_mask;
   logic [64:0] w_sh, w_diff;
   logic        w_fit;
   logic [63:0] w_quo_nxt, w_rem_nxt, w_q_s, w_r_s, w_pick, w_calc_res;

   // Operands viewed at the selected width, then reduced to magnitudes
   assign w_a64 = i_word ? (i_unsigned ? {32'd0, i_op1[31:0]} : {{32{i_op1[31]}}, i_op1[31:0]}) : i_op1;
   assign w_b64 = i_word ? (i_unsigned ? {32'd0, i_op2[31:0]} : {{32{i_op2[31]}}, i_op2[31:0]}) : i_op2;
   assign w_a_neg = !i_unsigned && w_a64[63];
   assign w_b_neg = !i_unsigned && w_b64[63];
   assign w_a_mag = w_a_neg ? (~w_a64 + 64'd1) : w_a64;
   assign w_b_mag = w_b_neg ? (~w_b64 + 64'd1) : w_b64;

   assign w_div0 = (w_b64 == 64'd0);
   assign w_ovf  = !i_unsigned && (w_b64 == {64{1'b1}}) &&
                   (i_word ? (w_a64 == {{33{1'b1}}, 31'd0}) : (w_a64 == {1'b1, 63'd0}));
   assign w_special  = w_div0 || w_ovf;
   assign w_spec_raw = w_div0 ? (i_rem ? w_a64 : {64{1'b1}}) : (i_rem ? 64'd0 : w_a64);
   assign w_spec_res = i_word ? {{32{w_spec_raw[31]}}, w_spec_raw[31:0]} : w_spec_raw;
   assign w_mask     = (32'd1 << i_rs1) | (32'd1 << i_rs2) | (32'd1 << i_rd);

   // Partial remainder never exceeds the divisor, so a 65-bit trial subtract suffices
   assign w_sh      = {r_rem, r_quo[63]};
   assign w_diff    = w_sh - {1'b0, r_div};
   assign w_fit     = !w_diff[64];
   assign w_rem_nxt = w_fit ? w_diff[63:0] : w_sh[63:0];
   assign w_quo_nxt = {r_quo[62:0], w_fit};

   assign w_q_s      = r_neg_q ? (~w_quo_nxt + 64'd1) : w_quo_nxt;
   assign w_r_s      = r_neg_r ? (~w_rem_nxt + 64'd1) : w_rem_nxt;
   assign w_pick     = r_sel_rem ? w_r_s : w_q_s;
   assign w_calc_res = r_word ? {{32{w_pick[31]}}, w_pick[31:0]} : w_pick;

   assign w_accept   = (r_state == S_DONE) && i_wb_ready && i_rst_n;
   assign o_ready    = (r_state == S_IDLE);
   assign o_wb_valid = (r_state == S_DONE);
   assign o_wb_rd    = r_rd;
   assign o_wb_data  = r_result;
   assign o_retire   = w_accept ? r_mask : 32'd0;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (i_valid) w_state_nxt = w_special ? S_DONE : S_CALC;
         S_CALC: if (r_cnt == 6'd0) w_state_nxt = S_DONE;
         S_DONE: if (w_accept) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= 6'd0;
         r_quo     <= 64'd0;
         r_rem     <= 64'd0;
         r_div     <= 64'd0;
         r_result  <= 64'd0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_word    <= 1'b0;
         r_sel_rem <= 1'b0;
         r_rd      <= 5'd0;
         r_mask    <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (i_valid) begin
                  // Word ops park the 32-bit magnitude at the top so its MSB shifts out first
                  r_quo     <= i_word ? {w_a_mag[31:0], 32'd0} : w_a_mag;
                  r_rem     <= 64'd0;
                  r_div     <= w_b_mag;
                  r_cnt     <= i_word ? 6'd31 : 6'd63;
                  r_neg_q   <= w_a_neg ^ w_b_neg;
                  r_neg_r   <= w_a_neg;
                  r_word    <= i_word;
                  r_sel_rem <= i_rem;
                  r_rd      <= i_rd;
                  r_mask    <= w_mask;
                  if (w_special) r_result <= w_spec_res;
               end
            end
            S_CALC: begin
               r_quo <= w_quo_nxt;
               r_rem <= w_rem_nxt;
               if (r_cnt != 6'd0) r_cnt <= r_cnt - 6'd1;
               else               r_result <= w_calc_res;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_warp_xdiv.sv
// Bench for warp_xdiv: directed corner ops plus random ops against a plain-arithmetic
// divide model, with latency, hold, retire-pulse and mid-op reset checks.
module tb_warp_xdiv;

   logic        i_clk, i_rst_n, i_valid, o_ready;
   logic [63:0] i_op1, i_op2;
   logic        i_unsigned, i_word, i_rem;
   logic [4:0]  i_rs1, i_rs2, i_rd;
   logic        o_wb_valid, i_wb_ready;
   logic [4:0]  o_wb_rd;
   logic [63:0] o_wb_data;
   logic [31:0] o_retire;

   int n_chk  = 0;
   int n_pass = 0;

   warp_xdiv dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_op1(i_op1), .i_op2(i_op2), .i_unsigned(i_unsigned), .i_word(i_word),
      .i_rem(i_rem), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
      .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_rd(o_wb_rd),
      .o_wb_data(o_wb_data), .o_retire(o_retire)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // Operand at the width the op works on: 32-bit values sign/zero-extended to 64
   function automatic logic [63:0] widen(input logic [63:0] v, input logic uns, input logic word);
      if (!word) return v;
      return uns ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
   endfunction

   function automatic bit is_special(input logic [63:0] a, input logic [63:0] b,
                                     input logic uns, input logic word);
      logic [63:0] ua, ub, most_neg;
      ua = widen(a, uns, word);
      ub = widen(b, uns, word);
      most_neg = word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
      return (ub == 64'd0) || (!uns && ua == most_neg && ub == {64{1'b1}});
   endfunction

   function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                           input logic uns, input logic word, input logic rem);
      logic [63:0] ua, ub, r;
      logic signed [63:0] sa, sb;
      ua = widen(a, uns, word);
      ub = widen(b, uns, word);
      sa = ua;
      sb = ub;
      if (ub == 64'd0)               r = rem ? ua : {64{1'b1}};
      else if (is_special(a, b, uns, word)) r = rem ? 64'd0 : ua;
      else if (uns)                  r = rem ? (ua % ub) : (ua / ub);
      else if (rem)                  r = sa % sb;
      else                           r = sa / sb;
      return word ? {{32{r[31]}}, r[31:0]} : r;
   endfunction

   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic uns,
                         input logic word, input logic rem, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input int hold);
      logic [63:0] exp_data;
      logic [31:0] exp_mask;
      int          exp_lat, n;
      bit          early;
      exp_data = ref_div(a, b, uns, word, rem);
      exp_mask = (32'd1 << rs1) | (32'd1 << rs2) | (32'd1 << rd);
      exp_lat  = is_special(a, b, uns, word) ? 1 : (word ? 33 : 65);
      chk("ready_idle", o_ready, 1);
      i_op1 = a; i_op2 = b; i_unsigned = uns; i_word = word; i_rem = rem;
      i_rs1 = rs1; i_rs2 = rs2; i_rd = rd; i_valid = 1'b1;
      i_wb_ready = (hold == 0);
      @(posedge i_clk); #1;
      // Scramble op inputs after acceptance; the unit must have captured them
      i_op1 = {$urandom, $urandom}; i_op2 = {$urandom, $urandom};
      i_unsigned = 1'($urandom); i_word = 1'($urandom); i_rem = 1'($urandom);
      i_rs1 = 5'($urandom); i_rs2 = 5'($urandom); i_rd = 5'($urandom);
      n = 1; early = 0;
      while (!o_wb_valid && n < 100) begin
         i_valid = 1'($urandom);
         if (o_retire != 32'd0 || o_ready) early = 1;
         @(posedge i_clk); #1;
         n++;
      end
      i_valid = 1'b0;
      chk("latency", n, exp_lat);
      chk("calc_quiet", early, 0);
      chk("wb_data", o_wb_data, exp_data);
      chk("wb_rd", o_wb_rd, rd);
      for (int k = 0; k < hold; k++) begin
         chk("hold_valid", o_wb_valid, 1);
         chk("hold_ready", o_ready, 0);
         chk("hold_retire", o_retire, 0);
         chk("hold_data", o_wb_data, exp_data);
         chk("hold_rd", o_wb_rd, rd);
         @(posedge i_clk); #1;
      end
      i_wb_ready = 1'b1;
      #1;
      chk("retire", o_retire, exp_mask);
      @(posedge i_clk); #1;
      chk("post_ready", o_ready, 1);
      chk("post_valid", o_wb_valid, 0);
      chk("post_retire", o_retire, 0);
   endtask

   initial begin
      logic [63:0] a, b;
      logic [4:0]  rd;
      bit          leak;
      i_rst_n = 1'b0; i_valid = 1'b0; i_op1 = '0; i_op2 = '0;
      i_unsigned = 0; i_word = 0; i_rem = 0; i_rs1 = 0; i_rs2 = 0; i_rd = 0;
      i_wb_ready = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_ready", o_ready, 1);
      chk("rst_valid", o_wb_valid, 0);
      chk("rst_rd", o_wb_rd, 0);
      chk("rst_data", o_wb_data, 0);
      chk("rst_retire", o_retire, 0);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      // Directed corner ops
      run_op(-64'sd7, 64'd2, 0, 0, 0, 5'd1, 5'd2, 5'd3, 0);
      run_op(-64'sd7, 64'd2, 0, 0, 1, 5'd4, 5'd5, 5'd6, 0);
      run_op(64'd7, 64'd2, 1, 0, 1, 5'd7, 5'd8, 5'd9, 0);
      run_op(64'd5, 64'd0, 1, 0, 0, 5'd10, 5'd11, 5'd12, 0);
      run_op(64'd5, 64'd0, 1, 0, 1, 5'd13, 5'd14, 5'd15, 0);
      run_op(64'h8000_0000_0000_0000, {64{1'b1}}, 0, 0, 0, 5'd16, 5'd17, 5'd18, 0);
      run_op(64'h8000_0000_0000_0000, {64{1'b1}}, 0, 0, 1, 5'd19, 5'd20, 5'd21, 0);
      run_op(64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 1, 1, 0, 5'd22, 5'd23, 5'd24, 0);
      run_op(64'h0000_0000_FFFF_FFF9, 64'd2, 0, 1, 0, 5'd25, 5'd26, 5'd27, 0);
      run_op(64'h1234_5678_8000_0000, 64'h0000_0001_FFFF_FFFF, 0, 1, 0, 5'd28, 5'd29, 5'd30, 0);
      run_op(64'd100, 64'hFFFF_FFFF_0000_0000, 0, 1, 1, 5'd31, 5'd31, 5'd0, 0);
      run_op(-64'sd12345, 64'd77, 0, 0, 1, 5'd2, 5'd3, 5'd0, 3);

      // Random ops across widths, signedness and divisor classes
      for (int t = 0; t < 40; t++) begin
         a = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: b = {$urandom, $urandom};
            1: b = 64'($urandom_range(1, 20));
            2: b = -64'($urandom_range(1, 20));
            3: b = 64'd0;
            4: begin
               b = {64{1'b1}};
               a = ($urandom_range(0, 1) == 0) ? 64'h8000_0000_0000_0000 : {32'($urandom), 32'h8000_0000};
            end
            default: b = {32'($urandom), 32'($urandom_range(0, 3))};
         endcase
         if ($urandom_range(0, 2) == 0) a = a >> $urandom_range(1, 60);
         rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
         run_op(a, b, 1'($urandom), 1'($urandom), 1'($urandom),
                5'($urandom), 5'($urandom), rd, ($urandom_range(0, 3) == 0) ? 2 : 0);
      end

      // Reset mid-calculation aborts the op with no writeback or retire
      i_op1 = 64'd999_999; i_op2 = 64'd7; i_unsigned = 0; i_word = 0; i_rem = 0;
      i_rs1 = 5'd8; i_rs2 = 5'd9; i_rd = 5'd10; i_valid = 1'b1; i_wb_ready = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      repeat (10) @(posedge i_clk);
      #1;
      chk("calc_busy", o_ready, 0);
      i_rst_n = 1'b0;
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      chk("abort_ready", o_ready, 1);
      chk("abort_valid", o_wb_valid, 0);
      chk("abort_data", o_wb_data, 0);
      chk("abort_rd", o_wb_rd, 0);
      leak = 0;
      for (int k = 0; k < 80; k++) begin
         if (o_retire != 32'd0 || o_wb_valid) leak = 1;
         @(posedge i_clk); #1;
      end
      chk("abort_no_retire", leak, 0);
      run_op(64'd1000, 64'd7, 1, 0, 0, 5'd1, 5'd1, 5'd1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
